// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared state encoding and default width for serial_adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int SERIAL_ADDER_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_RUN  = RUN,
    S_DONE = DONE
  } state_e;

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/addbit.sv
// ============================================================================
// Module      : addbit
// Description : 1-bit full adder cell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addbit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (a & ci) | (b & ci);

endmodule : addbit

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial WIDTH-bit adder built around one addbit cell,
//               LSB first, WIDTH cycles per add. Optional macro
//               SERIAL_ADDER_OVF_EN adds a registered two's-complement ovf.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state;
  state_e             state_nxt;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               s_bit;
  logic               c_bit;
  logic [WIDTH-1:0]   sum_nxt;
  logic               accept;
  logic               last;

  assign accept = start && ((state == S_IDLE) || (state == S_DONE));
  assign last   = (state == S_RUN) && (cnt == CNT_W'(WIDTH - 1));

  addbit u_addbit (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .ci  (carry),
    .sum (s_bit),
    .co  (c_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = start ? S_RUN : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Only WIDTH-1 partial sum bits need storing: the newest bit comes straight
  // from the adder on the final edge.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_nxt = s_bit;
    end else begin : g_sum_wn
      logic [WIDTH-2:0] sum_sh;

      assign sum_nxt = {s_bit, sum_sh};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum_sh <= '0;
        end else if (state == S_RUN) begin
          sum_sh <= sum_nxt[WIDTH-1:1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum_out <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else if (accept) begin
      a_sh  <= a_in;
      b_sh  <= b_in;
      carry <= cin;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= c_bit;
      cnt   <= cnt + CNT_W'(1);
      if (last) begin
        sum_out <= sum_nxt;
        cout    <= c_bit;
`ifdef SERIAL_ADDER_OVF_EN
        // Operand MSBs sit at bit 0 of the shifters on the final edge.
        ovf     <= (a_sh[0] == b_sh[0]) && (s_bit != a_sh[0]);
`endif
      end
    end
  end

endmodule : serial_adder

`default_nettype wire

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: vector table, hand-written corner sequences,
// random operands against an arithmetic model, and a WIDTH=1 instance.
`default_nettype none

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a_in, b_in;
  logic       cin;
  logic       busy, done, cout;
  logic [7:0] sum_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  logic       start1, a1, b1, cin1;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf1;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
    .busy(busy), .done(done), .sum_out(sum_out),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf),
`endif
    .cout(cout)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum_out(sum1),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf1),
`endif
    .cout(cout1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one add with a single-cycle start pulse; report results and timing.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output logic [7:0] s, output logic co, output logic ov,
                        output int lat, output int busy_cnt, output int overlap);
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b; cin = c;
    @(negedge clk);
    start = 1'b0; a_in = $urandom; b_in = $urandom; cin = $urandom;
    lat = 0; busy_cnt = 0; overlap = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (busy && done) overlap++;
    s = sum_out; co = cout;
`ifdef SERIAL_ADDER_OVF_EN
    ov = ovf;
`else
    ov = 1'b0;
`endif
  endtask

  vec_t       vecs[7];
  logic [7:0] s;
  logic       co, ov;
  int         lat, bcnt, ovl;
  logic [8:0] ref_full;
  logic [7:0] ra, rb;
  logic       rc;
  int         seen_done;

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h40, 8'h10, 1'b0, 8'h50, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_sum", {24'd0, sum_out}, 32'd0);
    chk("reset_cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, s, co, ov, lat, bcnt, ovl);
      chk($sformatf("vec%0d_sum", i), {24'd0, s}, {24'd0, vecs[i].exp_sum});
      chk($sformatf("vec%0d_cout", i), {31'd0, co}, {31'd0, vecs[i].exp_cout});
      chk($sformatf("vec%0d_latency", i), lat, 32'd8);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, 32'd8);
      chk($sformatf("vec%0d_busy_done_overlap", i), ovl, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      chk($sformatf("vec%0d_ovf", i), {31'd0, ov}, {31'd0, vecs[i].exp_ovf});
`endif
    end

    // Back-to-back: start held high through RUN and DONE.
    @(negedge clk);
    start = 1'b1; a_in = 8'h01; b_in = 8'h02; cin = 1'b0;
    @(negedge clk);
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk("b2b_first_latency", lat, 32'd8);
    chk("b2b_first_sum", {24'd0, sum_out}, 32'h03);
    a_in = 8'h10; b_in = 8'h20;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_no_gap_busy", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk("b2b_second_latency", lat, 32'd8);
    chk("b2b_second_sum", {24'd0, sum_out}, 32'h30);

    // Start pulsed mid-RUN is ignored.
    @(negedge clk);
    start = 1'b1; a_in = 8'h11; b_in = 8'h22; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; a_in = 8'hFF; b_in = 8'hFF; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 4;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk("midrun_start_latency", lat, 32'd8);
    chk("midrun_start_sum", {24'd0, sum_out}, 32'h33);
    chk("midrun_start_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    chk("midrun_idle_after", {31'd0, busy}, 32'd0);

    // Reset four cycles into an add aborts it.
    @(negedge clk);
    start = 1'b1; a_in = 8'hAA; b_in = 8'h55; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_sum", {24'd0, sum_out}, 32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    seen_done = 0;
    repeat (3) begin @(negedge clk); if (done) seen_done++; end
    rst = 1'b0;
    repeat (10) begin @(negedge clk); if (done) seen_done++; end
    chk("abort_no_done", seen_done, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    run_op(8'h01, 8'h01, 1'b0, s, co, ov, lat, bcnt, ovl);
    chk("post_abort_sum", {24'd0, s}, 32'h02);
    chk("post_abort_latency", lat, 32'd8);

    // Random operands against plain arithmetic.
    for (int i = 0; i < 25; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      ref_full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      run_op(ra, rb, rc, s, co, ov, lat, bcnt, ovl);
      chk($sformatf("rand%0d_result", i), {23'd0, co, s}, {23'd0, ref_full});
      chk($sformatf("rand%0d_latency", i), lat, 32'd8);
`ifdef SERIAL_ADDER_OVF_EN
      chk($sformatf("rand%0d_ovf", i), {31'd0, ov},
          {31'd0, (ra[7] == rb[7]) && (ref_full[7] != ra[7])});
`endif
    end

    // WIDTH=1 instance.
    @(negedge clk);
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("w1_busy", {31'd0, busy1}, 32'd1);
    lat = 0;
    while (!done1 && lat < 10) begin @(negedge clk); lat++; end
    chk("w1_latency", lat, 32'd1);
    chk("w1_sum", {31'd0, sum1}, 32'd1);
    chk("w1_cout", {31'd0, cout1}, 32'd1);
    @(negedge clk);
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
    @(negedge clk);
    start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 10) begin @(negedge clk); lat++; end
    chk("w1b_latency", lat, 32'd1);
    chk("w1b_result", {30'd0, cout1, sum1}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_serial_adder

`default_nettype wire
